// File: rtl/divider_arbiter.sv
// Two-requester round-robin front end sharing one restoring divider (W cycles + fixup).
// Build option: define DIVIDER_ARBITER_SIGNED_EN for two's-complement operands.
module divider_arbiter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_req0_valid,
  input  logic         i_req1_valid,
  output logic         o_req0_ready,
  output logic         o_req1_ready,
  input  logic [W-1:0] i_req0_q,
  input  logic [W-1:0] i_req1_q,
  input  logic [W-1:0] i_req0_m,
  input  logic [W-1:0] i_req1_m,
  output logic         o_rsp_valid,
  input  logic         i_rsp_ready,
  output logic         o_rsp_id,
  output logic [W-1:0] o_quo,
  output logic [W-1:0] o_rem,
  output logic         o_dbz,
  output logic         o_busy
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, ITER, FIXUP, RESP} state_t;

  state_t        state, state_nxt;
  logic          prio;        // 1: req1 wins the next contention
  logic [CW-1:0] cnt;
  logic [W-1:0]  acc_q;       // dividend shifts out, quotient bits shift in
  logic [W-1:0]  rem_r;
  logic [W-1:0]  div_m;
  logic          accept, acc_id;
  logic [W-1:0]  sel_q, sel_m, mag_q, mag_m;
  logic [W:0]    shifted;
  logic          fits;
  logic [W-1:0]  rem_nxt;

`ifdef DIVIDER_ARBITER_SIGNED_EN
  logic neg_q, neg_m;
  assign mag_q = sel_q[W-1] ? -sel_q : sel_q;
  assign mag_m = sel_m[W-1] ? -sel_m : sel_m;
`else
  assign mag_q = sel_q;
  assign mag_m = sel_m;
`endif

  assign accept  = o_req0_ready | o_req1_ready;
  assign acc_id  = o_req1_ready;
  assign sel_q   = acc_id ? i_req1_q : i_req0_q;
  assign sel_m   = acc_id ? i_req1_m : i_req0_m;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  assign shifted = {rem_r, acc_q[W-1]};
  assign fits    = shifted >= {1'b0, div_m};
  assign rem_nxt = fits ? W'(shifted - {1'b0, div_m}) : shifted[W-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (sel_m == '0) ? RESP : ITER;
      ITER:    if (cnt == '0) state_nxt = FIXUP;
      FIXUP:   state_nxt = RESP;
      RESP:    if (i_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    o_rsp_valid  = 1'b0;
    o_busy       = 1'b0;
    if (!i_rst) begin
      o_busy      = (state != IDLE);
      o_rsp_valid = (state == RESP);
      if (state == IDLE) begin
        o_req0_ready = i_req0_valid && (!i_req1_valid || !prio);
        o_req1_ready = i_req1_valid && (!i_req0_valid || prio);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prio     <= 1'b0;
      cnt      <= '0;
      acc_q    <= '0;
      rem_r    <= '0;
      div_m    <= '0;
      o_rsp_id <= 1'b0;
      o_quo    <= '0;
      o_rem    <= '0;
      o_dbz    <= 1'b0;
`ifdef DIVIDER_ARBITER_SIGNED_EN
      neg_q    <= 1'b0;
      neg_m    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          prio     <= ~acc_id;
          o_rsp_id <= acc_id;
          acc_q    <= mag_q;
          div_m    <= mag_m;
          rem_r    <= '0;
          cnt      <= CW'(W-1);
`ifdef DIVIDER_ARBITER_SIGNED_EN
          neg_q    <= sel_q[W-1];
          neg_m    <= sel_m[W-1];
`endif
          if (sel_m == '0) begin
            o_quo <= '1;
            o_rem <= sel_q;
            o_dbz <= 1'b1;
          end
        end
        ITER: begin
          acc_q <= {acc_q[W-2:0], fits};
          rem_r <= rem_nxt;
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        FIXUP: begin
`ifdef DIVIDER_ARBITER_SIGNED_EN
          o_quo <= (neg_q ^ neg_m) ? -acc_q : acc_q;
          o_rem <= neg_q ? -rem_r : rem_r;
`else
          o_quo <= acc_q;
          o_rem <= rem_r;
`endif
          o_dbz <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/divider_arbiter.md
DIVIDER_ARBITER -- requirements
Module: divider_arbiter

Interface
REQ-001 SHALL have parameter W, default 8: dividend, divisor, quotient and remainder width in bits.
REQ-002 SHALL have port i_clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have ports i_req0_valid / i_req1_valid, input, 1 each: requester n has an operand pair pending.
REQ-005 SHALL have ports o_req0_ready / o_req1_ready, output, 1 each: requester n is accepted this cycle.
REQ-006 SHALL have ports i_req0_q / i_req1_q, input, W each: dividend of requester n.
REQ-007 SHALL have ports i_req0_m / i_req1_m, input, W each: divisor of requester n.
REQ-008 SHALL have port o_rsp_valid, output, 1: a result is presented.
REQ-009 SHALL have port i_rsp_ready, input, 1: the consumer takes the result.
REQ-010 SHALL have port o_rsp_id, output, 1: index of the requester that owns the result.
REQ-011 SHALL have ports o_quo and o_rem, output, W each: quotient and remainder.
REQ-012 SHALL have port o_dbz, output, 1: the divisor was zero.
REQ-013 SHALL have port o_busy, output, 1: high in every state except IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, ITER, FIXUP and RESP; there is one shared restoring-division datapath.
REQ-015 SHALL accept a request only in IDLE: a transfer is valid&&ready on the same requester; at most one ready is high per cycle.
REQ-016 SHALL arbitrate round-robin when both valids are high: grant the requester not granted last. After reset, req0 has priority.
REQ-017 SHALL compute ready combinationally from the valids and the priority pointer, and SHALL update the pointer only on acceptance.
REQ-018 SHALL, on acceptance, latch the operands and the id, clear the partial remainder, and enter ITER with counter = W-1.
REQ-019 SHALL, in ITER, perform one shift/subtract/restore step per cycle for exactly W cycles, then enter FIXUP.
REQ-020 SHALL, in FIXUP, apply sign correction (REQ-031) or pass through, register the outputs, and enter RESP.
REQ-021 SHALL raise o_rsp_valid exactly W+2 cycles after the acceptance cycle (10 cycles for W=8).
REQ-022 SHALL, when the divisor is zero, skip ITER and FIXUP and enter RESP on the next cycle with o_quo = all ones, o_rem = the dividend, and o_dbz = 1.
REQ-023 SHALL, in RESP, hold o_rsp_valid, o_rsp_id, o_quo, o_rem and o_dbz stable until i_rsp_ready is high, then return to IDLE.
REQ-024 SHALL keep both readys low in the RESP handshake cycle, so the next acceptance happens one cycle later at the earliest.
REQ-025 SHALL ignore requester valids and operand changes while busy; latched operands are unaffected.
REQ-026 SHALL drive o_rsp_valid low outside RESP; o_quo, o_rem and o_dbz keep their last values.

Reset
REQ-027 SHALL, while i_rst is high, force state = IDLE, priority pointer = req0, counter = 0, and all outputs = 0, including both readys.
REQ-028 SHALL abandon any in-flight operation when i_rst is asserted in any state; no response is produced for that request.
REQ-029 SHALL allow the first acceptance in the cycle after i_rst deasserts.

Configuration
REQ-030 SHALL use macro DIVIDER_ARBITER_SIGNED_EN to select signed operation.
REQ-031 SHALL, with the macro defined, treat operands as two's complement:
- divide magnitudes;
- quotient truncated toward zero, negated if the operand signs differ;
- remainder takes the dividend's sign;
- most-negative / -1 yields quotient = most-negative, remainder = 0.
REQ-032 SHALL, without the macro, treat operands as unsigned, make FIXUP a pass-through, and keep latency unchanged at W+2.

Verification
REQ-033 SHALL cover a single request: req0 q=125, m=3 -> o_quo=41, o_rem=2, o_rsp_id=0, o_dbz=0, o_rsp_valid 10 cycles after acceptance.
REQ-034 SHALL cover contention: both valid, req0 100/7 and req1 200/9 -> req0 served first (14 r2), then req1 (22 r2); a second contention grants req1 first.
REQ-035 SHALL cover divide by zero: req1 q=77, m=0 -> o_dbz=1, o_quo=255, o_rem=77, o_rsp_valid 1 cycle after acceptance.
REQ-036 SHALL cover backpressure: i_rsp_ready low for 5 cycles during RESP -> outputs stable; readys stay low until the cycle after the handshake.
REQ-037 SHALL cover reset mid-operation: i_rst pulsed during the 4th ITER cycle -> all outputs 0, no response, req0 accepted first afterward.
REQ-038 SHALL cover both configurations:
- signed: q=-7, m=3 -> quo=-2, rem=-1; q=7, m=-3 -> quo=-2, rem=1;
- unsigned: q=249, m=3 -> quo=83, rem=0.
